obstacle_lane: RTL and testbench



---
 rtl/obstacle_lane_if.sv | 26 ++
 rtl/obstacle_lane.sv | 185 ++++++++++++++++++
 tb/tb_obstacle_lane.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_lane_if.sv
// Pixel-write bus plus control/status bundle between the game controller and one obstacle lane.
// The slave modport is the lane engine; the master modport is the controller side.
interface obstacle_lane_if;
  logic       go;
  logic       enable;
  logic [2:0] colour_in;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic [7:0] obs_x;
  logic       hit;

  modport slave (
    input  go, enable, colour_in, player_x, player_y,
    output x_out, y_out, colour_out, plot, busy, obs_x, hit
  );

  modport master (
    output go, enable, colour_in, player_x, player_y,
    input  x_out, y_out, colour_out, plot, busy, obs_x, hit
  );
endinterface

// File: rtl/obstacle_lane.sv
// Moving-obstacle engine for one road lane: draws, waits a number of frames, erases,
// steps (bounce or wrap) and redraws a sprite block on the shared pixel bus.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | waiting for go
//   S_GO_WAIT | go seen, waiting for its release
//   S_DRAW    | raster scan of the block in colour_in
//   S_WAIT    | counting frame ticks while enabled
//   S_ERASE   | raster scan of the block in black
//   S_MOVE    | one cycle: step obs_x, maybe flip direction
module obstacle_lane #(
  parameter int SPRITE_W        = 8,
  parameter int SPRITE_H        = 8,
  parameter int LANE_Y          = 85,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 159,
  parameter int START_X         = 0,
  parameter int DIR_INIT        = 1,
  parameter int STEP            = 1,
  parameter int WRAP_MODE       = 0,
  parameter int DELAY_CYCLES    = 833333,
  parameter int FRAMES_PER_MOVE = 8,
  parameter int PLAYER_W        = 8,
  parameter int PLAYER_H        = 8
) (
  input logic            clk,
  input logic            resetn,
  obstacle_lane_if.slave bus
);

  localparam int XR = X_MAX - SPRITE_W + 1;
  localparam int PW = 5;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GO_WAIT, S_DRAW, S_WAIT, S_ERASE, S_MOVE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    obs_x_q, obs_x_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          hit_q, hit_d;
  logic [8:0]    ox9, sum9;
  logic          scan;

  always_comb begin
    state_d = state_q;
    obs_x_d = obs_x_q;
    dir_d   = dir_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dly_d   = '0;
    frm_d   = '0;
    ox9     = {1'b0, obs_x_q};
    sum9    = ox9 + 9'(STEP);
    unique case (state_q)
      S_IDLE: if (bus.go) state_d = S_GO_WAIT;
      S_GO_WAIT: begin
        if (!bus.go) begin
          state_d = S_DRAW;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      S_DRAW, S_ERASE: begin
        if (cx_q == PW'(SPRITE_W - 1)) begin
          cx_d = '0;
          if (cy_q == PW'(SPRITE_H - 1)) begin
            cy_d    = '0;
            state_d = (state_q == S_DRAW) ? S_WAIT : S_MOVE;
          end else begin
            cy_d = cy_q + PW'(1);
          end
        end else begin
          cx_d = cx_q + PW'(1);
        end
      end
      S_WAIT: begin
        dly_d = dly_q;
        frm_d = frm_q;
        if (bus.enable) begin
          if (dly_q == DW'(DELAY_CYCLES - 1)) begin
            dly_d = '0;
            if (frm_q == FW'(FRAMES_PER_MOVE - 1)) begin
              frm_d   = '0;
              state_d = S_ERASE;
            end else begin
              frm_d = frm_q + FW'(1);
            end
          end else begin
            dly_d = dly_q + DW'(1);
          end
        end
      end
      S_MOVE: begin
        state_d = S_DRAW;
        cx_d    = '0;
        cy_d    = '0;
        // 9-bit compares keep edge detection correct near the top of the 8-bit range
        if (dir_q) begin
          if (sum9 > 9'(XR)) begin
            if (WRAP_MODE != 0) obs_x_d = 8'(X_MIN);
            else begin
              dir_d   = 1'b0;
              obs_x_d = 8'(ox9 - 9'(STEP));
            end
          end else begin
            obs_x_d = sum9[7:0];
          end
        end else begin
          if (ox9 < 9'(X_MIN + STEP)) begin
            if (WRAP_MODE != 0) obs_x_d = 8'(XR);
            else begin
              dir_d   = 1'b1;
              obs_x_d = sum9[7:0];
            end
          end else begin
            obs_x_d = 8'(ox9 - 9'(STEP));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pixel outputs are computed from the next state so plot lines up with DRAW/ERASE
    scan     = (state_d == S_DRAW) || (state_d == S_ERASE);
    plot_d   = scan;
    x_d      = scan ? (obs_x_d + 8'(cx_d)) : x_q;
    y_d      = scan ? (7'(LANE_Y) + 7'(cy_d)) : y_q;
    colour_d = (state_d == S_DRAW) ? bus.colour_in : 3'b000;

    hit_d = ({2'b0, obs_x_q} < ({2'b0, bus.player_x} + 10'(PLAYER_W))) &&
            ({2'b0, bus.player_x} < ({2'b0, obs_x_q} + 10'(SPRITE_W))) &&
            (10'(LANE_Y) < ({3'b0, bus.player_y} + 10'(PLAYER_H))) &&
            ({3'b0, bus.player_y} < 10'(LANE_Y + SPRITE_H));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      obs_x_q  <= 8'(START_X);
      dir_q    <= (DIR_INIT != 0);
      cx_q     <= '0;
      cy_q     <= '0;
      dly_q    <= '0;
      frm_q    <= '0;
      x_q      <= 8'(START_X);
      y_q      <= 7'(LANE_Y);
      colour_q <= 3'b000;
      plot_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      obs_x_q  <= obs_x_d;
      dir_q    <= dir_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      dly_q    <= dly_d;
      frm_q    <= frm_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      hit_q    <= hit_d;
    end
  end

  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.obs_x      = obs_x_q;
  assign bus.hit        = hit_q;

endmodule

// File: tb/tb_obstacle_lane.sv
// Bench for obstacle_lane: three lanes (mid-road bounce, right-edge bounce, right-edge wrap)
// driven with shared random inputs and compared against a segment-level timeline model.
module tb_obstacle_lane;
  localparam int W = 4, H = 4, N = W * H, LY = 85, XMAX = 159, XR = XMAX - W + 1;
  localparam int D = 4, F = 2, PLW = 8, PLH = 8, K = 400;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  obstacle_lane_if bus0 ();
  obstacle_lane_if bus1 ();
  obstacle_lane_if bus2 ();

  obstacle_lane #(.SPRITE_W(W), .SPRITE_H(H), .LANE_Y(LY), .X_MIN(0), .X_MAX(XMAX),
    .START_X(10), .DIR_INIT(1), .STEP(1), .WRAP_MODE(0), .DELAY_CYCLES(D),
    .FRAMES_PER_MOVE(F), .PLAYER_W(PLW), .PLAYER_H(PLH))
    u_dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  obstacle_lane #(.SPRITE_W(W), .SPRITE_H(H), .LANE_Y(LY), .X_MIN(0), .X_MAX(XMAX),
    .START_X(XR), .DIR_INIT(1), .STEP(2), .WRAP_MODE(0), .DELAY_CYCLES(D),
    .FRAMES_PER_MOVE(F), .PLAYER_W(PLW), .PLAYER_H(PLH))
    u_dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  obstacle_lane #(.SPRITE_W(W), .SPRITE_H(H), .LANE_Y(LY), .X_MIN(0), .X_MAX(XMAX),
    .START_X(XR), .DIR_INIT(1), .STEP(2), .WRAP_MODE(1), .DELAY_CYCLES(D),
    .FRAMES_PER_MOVE(F), .PLAYER_W(PLW), .PLAYER_H(PLH))
    u_dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  int st_x[3]    = '{10, XR, XR};
  int st_step[3] = '{1, 2, 2};
  int st_wrap[3] = '{0, 0, 1};

  bit         en_a[K];
  bit         go_a[K];
  logic [2:0] col_a[K];
  logic [7:0] px_a[K];
  logic [6:0] py_a[K];
  int e_plot[3][K], e_x[3][K], e_y[3][K], e_c[3][K], e_obs[3][K];
  int prev_obs[3];

  logic [7:0] xs[3], obs_s[3];
  logic [6:0] ys[3];
  logic [2:0] cs[3];
  logic       plot_s[3], busy_s[3], hit_s[3];

  function automatic bit overlap(int ox, int px, int py);
    return (ox < px + PLW) && (px < ox + W) && (LY < py + PLH) && (py < LY + H);
  endfunction

  task automatic set_exp(int d, int k, int p, int x, int y, int c, int o);
    if (k < K) begin
      e_plot[d][k] = p; e_x[d][k] = x; e_y[d][k] = y; e_c[d][k] = c; e_obs[d][k] = o;
    end
  endtask

  // Timeline: draw N, wait until F*D enabled cycles, erase N, one move cycle, repeat
  task automatic build_model(int d);
    int pos, dir, k, j, cnt;
    pos = st_x[d]; dir = 1; k = 0;
    while (k < K) begin
      for (int i = 0; i < N; i++)
        set_exp(d, k + i, 1, pos + i % W, LY + i / W, (k + i < K) ? int'(col_a[k + i]) : 0, pos);
      k += N;
      j = k; cnt = 0;
      while (cnt < F * D && j < K - 1) begin
        j++;
        if (en_a[j]) cnt++;
      end
      if (cnt < F * D) j = K;
      for (int i = k; i < j; i++) set_exp(d, i, 0, 0, 0, 0, pos);
      k = j;
      for (int i = 0; i < N; i++) set_exp(d, k + i, 1, pos + i % W, LY + i / W, 0, pos);
      k += N;
      set_exp(d, k, 0, 0, 0, 0, pos);
      k++;
      if (dir == 1) begin
        if (pos + st_step[d] > XR) begin
          if (st_wrap[d] != 0) pos = 0;
          else begin dir = 0; pos = pos - st_step[d]; end
        end else pos = pos + st_step[d];
      end else begin
        if (pos < st_step[d]) begin
          if (st_wrap[d] != 0) pos = XR;
          else begin dir = 1; pos = pos + st_step[d]; end
        end else pos = pos - st_step[d];
      end
    end
  endtask

  task automatic set_in(bit g, bit e, logic [2:0] c, logic [7:0] px, logic [6:0] py);
    bus0.go = g; bus0.enable = e; bus0.colour_in = c; bus0.player_x = px; bus0.player_y = py;
    bus1.go = g; bus1.enable = e; bus1.colour_in = c; bus1.player_x = px; bus1.player_y = py;
    bus2.go = g; bus2.enable = e; bus2.colour_in = c; bus2.player_x = px; bus2.player_y = py;
  endtask

  task automatic sample();
    xs[0] = bus0.x_out; ys[0] = bus0.y_out; cs[0] = bus0.colour_out; plot_s[0] = bus0.plot;
    busy_s[0] = bus0.busy; obs_s[0] = bus0.obs_x; hit_s[0] = bus0.hit;
    xs[1] = bus1.x_out; ys[1] = bus1.y_out; cs[1] = bus1.colour_out; plot_s[1] = bus1.plot;
    busy_s[1] = bus1.busy; obs_s[1] = bus1.obs_x; hit_s[1] = bus1.hit;
    xs[2] = bus2.x_out; ys[2] = bus2.y_out; cs[2] = bus2.colour_out; plot_s[2] = bus2.plot;
    busy_s[2] = bus2.busy; obs_s[2] = bus2.obs_x; hit_s[2] = bus2.hit;
  endtask

  task automatic chk_reset(string tag);
    sample();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_x d%0d", tag, d), xs[d], st_x[d]);
      chk($sformatf("%s_y d%0d", tag, d), ys[d], LY);
      chk($sformatf("%s_colour d%0d", tag, d), cs[d], 0);
      chk($sformatf("%s_plot d%0d", tag, d), plot_s[d], 0);
      chk($sformatf("%s_busy d%0d", tag, d), busy_s[d], 0);
      chk($sformatf("%s_obs d%0d", tag, d), obs_s[d], st_x[d]);
      chk($sformatf("%s_hit d%0d", tag, d), hit_s[d], 0);
    end
  endtask

  task automatic idle_run(string tag, int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      sample();
      chk($sformatf("%s_plot c%0d", tag, i), plot_s[0] | plot_s[1] | plot_s[2], 0);
      chk($sformatf("%s_busy c%0d", tag, i), busy_s[0] | busy_s[1] | busy_s[2], 0);
    end
  endtask

  initial begin
    bit found;
    resetn = 1'b1;
    set_in(1'b0, 1'b1, 3'b101, 8'd13, 7'd88);
    #1 resetn = 1'b0;
    #2 chk_reset("por");

    for (int k = 0; k < K; k++) begin
      en_a[k]  = (k >= 18 && k < 38) ? 1'b0 : ($urandom_range(0, 3) != 0);
      go_a[k]  = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      col_a[k] = 3'($urandom_range(0, 7));
      px_a[k]  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(140, 159));
      py_a[k]  = 7'($urandom_range(75, 95));
    end
    for (int d = 0; d < 3; d++) build_model(d);

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle_run("idle", 50);

    set_in(1'b1, 1'b1, 3'b101, 8'd0, 7'd0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) prev_obs[d] = st_x[d];

    for (int k = 0; k < K; k++) begin
      set_in(go_a[k], en_a[k], col_a[k], px_a[k], py_a[k]);
      @(posedge clk);
      @(negedge clk);
      sample();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("plot d%0d k%0d", d, k), plot_s[d], e_plot[d][k]);
        if (e_plot[d][k] != 0) begin
          chk($sformatf("x d%0d k%0d", d, k), xs[d], e_x[d][k]);
          chk($sformatf("y d%0d k%0d", d, k), ys[d], e_y[d][k]);
          chk($sformatf("colour d%0d k%0d", d, k), cs[d], e_c[d][k]);
          chk($sformatf("xmax d%0d k%0d", d, k), 32'(xs[d] <= XMAX), 1);
        end
        chk($sformatf("obs d%0d k%0d", d, k), obs_s[d], e_obs[d][k]);
        chk($sformatf("hit d%0d k%0d", d, k), hit_s[d], 32'(overlap(prev_obs[d], px_a[k], py_a[k])));
        chk($sformatf("busy d%0d k%0d", d, k), busy_s[d], 1);
        prev_obs[d] = e_obs[d][k];
      end
    end

    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    set_in(1'b1, 1'b1, 3'b101, 8'd13, 7'd88);
    repeat (3) @(negedge clk);
    set_in(1'b0, 1'b1, 3'b101, 8'd13, 7'd88);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus0.plot === 1'b1 && bus0.colour_out === 3'b000) found = 1'b1;
    end
    chk("erase_seen", 32'(found), 1);
    chk("hit_during_erase", bus0.hit, 1);
    #3 resetn = 1'b0;
    #1 chk_reset("mid_erase");
    @(negedge clk);
    resetn = 1'b1;
    set_in(1'b0, 1'b1, 3'b101, 8'd13, 7'd88);
    idle_run("post_reset", 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_chk);
    $fatal(1, "timeout");
  end
endmodule
